delay_sched: RTL
================

# delay_sched

Per-sample scheduler for the delay core datapath. On each `step` tick it sequences one ADC conversion, one SPI RAM write of the new sample at the write pointer, one SPI RAM read of the delayed sample at the read pointer, and one DAC update with that delayed sample. It then advances both circular-buffer pointers. It sits between the sample-rate tick source and the ADC, RAM and DAC SPI engines, and drives them through start/done handshakes.

## Interface

Parameters:

- `RAM_END_ADDR`, 24'h01FFFF: last valid byte address of the circular buffer.
- `W_PTR_START_ADDR`, 24'h000000: write pointer value after reset.
- `R_PTR_START_ADDR`, 24'h01001C: read pointer value after reset. Must be even.
- `TIMEOUT_CYCLES`, 4096: per-engine watchdog limit. Used only with `DELAY_SCHED_TIMEOUT_EN`.

Ports:

- `clk`  in  1: single clock. All logic is on the rising edge.
- `nrst`  in  1: reset, synchronous, active-low.
- `step`  in  1: sample tick, level-sampled each cycle.
- `adc_start`  out  1: one-cycle pulse that starts an ADC conversion and readout.
- `adc_done`  in  1: ADC engine completion pulse.
- `adc_data`  in  16: ADC sample, valid in the `adc_done` cycle.
- `ram_start`  out  1: one-cycle pulse that starts a RAM transaction.
- `ram_wr`  out  1: 1 = write, 0 = read. Held stable from `ram_start` until `ram_done`.
- `ram_addr`  out  24: transaction byte address. Held stable during the transaction.
- `ram_wdata`  out  16: write data. Holds the last captured ADC sample.
- `ram_done`  in  1: RAM engine completion pulse.
- `ram_rdata`  in  16: read data, valid in the `ram_done` cycle.
- `dac_start`  out  1: one-cycle pulse that starts a DAC update.
- `dac_data`  out  16: DAC word. Holds the last delayed sample read.
- `dac_done`  in  1: DAC engine completion pulse.
- `busy`  out  1: high in every state except IDLE.
- `overrun`  out  1: sticky. Set when `step` is asserted while `busy`.
- `fault`  out  1: sticky. Set on a watchdog expiry. Tied 0 without `DELAY_SCHED_TIMEOUT_EN`.

## Operation

States and transitions:

- IDLE → ADC when `step`=1.
- ADC → RAM_WR on `adc_done`.
- RAM_WR → RAM_RD on `ram_done`.
- RAM_RD → DAC on `ram_done`.
- DAC → ADV on `dac_done`.
- ADV → IDLE unconditionally.

Per-state behaviour:

- **ADC, RAM_WR, RAM_RD, DAC (wait states):** the matching `*_start` pulses high for exactly one cycle, on the first cycle of the state.
  - The matching `*_done` is honoured only from the cycle after the start pulse.
  - Any `done` input belonging to a different engine is ignored.
- **ADC:** `adc_data` is captured into `ram_wdata` on `adc_done`.
- **RAM_WR:** `ram_wr`=1, `ram_addr` = write pointer.
- **RAM_RD:** `ram_wr`=0, `ram_addr` = read pointer. `ram_rdata` is captured into `dac_data` on `ram_done`.
- **ADV:** both pointers advance by 2 bytes (one 16-bit sample each).
  - Next pointer = 0 if ptr + 2 > `RAM_END_ADDR`, else ptr + 2.
  - Use 25-bit compare arithmetic so the addition cannot overflow.

Boundary rules:

- `step` asserted in any state other than IDLE sets `overrun` and is dropped; no queuing. This includes the ADV cycle.
- `overrun` and `fault` clear only on reset.
- Equal pointers are legal: the write completes before the read, so the read returns the current sample (zero delay).
- Reset mid-transaction:
  - The FSM returns to IDLE and no further starts are issued.
  - Pointers reload their start values.
  - The SPI engines are reset by the same `nrst`.

Reset values: all outputs 0, `ram_addr` 0, state IDLE, write pointer = `W_PTR_START_ADDR`, read pointer = `R_PTR_START_ADDR`.

## Timing

- `step` high in cycle N (IDLE) → `adc_start` high in cycle N+1, `busy` high from N+1.
- `*_done` in cycle M → next start pulse in cycle M+1.
- `dac_done` in cycle M → ADV in M+1 → IDLE in M+2, `busy` low in M+2.
- Earliest accepted next `step` is cycle M+2.
- Minimum sample period = 4 engine latencies + 6 cycles.
- `ram_addr` and `ram_wr` change only on state entry.

## Configuration

- `DELAY_SCHED_TIMEOUT_EN` defined:
  - A 16-bit counter runs in each wait state and resets on state entry.
  - If `done` has not arrived after `TIMEOUT_CYCLES` cycles: go to IDLE, set `fault`, leave pointers unadvanced, leave `dac_data` unchanged.
- Not defined: no counter, `fault` is constant 0, and wait states last indefinitely.

## Test plan

- Reset → all outputs 0, `busy`=0. The first RAM_WR uses `ram_addr`=24'h000000 and the first RAM_RD uses 24'h01001C.
- One `step` with ADC model returning 16'hA5A5 and RAM model returning 16'h1234 → exact order `adc_start`, `ram_start` (wr=1, addr 0, wdata A5A5), `ram_start` (wr=0, addr 01001C), `dac_start` with `dac_data`=1234. Each start is exactly one cycle.
- Write pointer preloaded at 24'h01FFFE via parameter → after one sample, the next write address is 24'h000000. A read pointer at 24'h01FFFE wraps likewise.
- `step` pulsed during RAM_RD and again during ADV → `overrun`=1, exactly one sample processed, pointers advanced by 2 only.
- `nrst` low during RAM_WR → next cycle state IDLE, outputs 0, pointers at start values; the following `step` runs a clean sequence.
- With `DELAY_SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES`=32, withhold `dac_done` → `fault`=1 after 32 cycles in DAC, FSM in IDLE, pointers unchanged.

Source files
------------

// File: rtl/delay_sched.sv
// Per-sample scheduler for the delay core: ADC capture -> RAM write -> RAM read -> DAC update.
// Optional per-engine watchdog enabled by defining DELAY_SCHED_TIMEOUT_EN.
module delay_sched #(
  parameter logic [23:0] RAM_END_ADDR     = 24'h01FFFF,
  parameter logic [23:0] W_PTR_START_ADDR = 24'h000000,
  parameter logic [23:0] R_PTR_START_ADDR = 24'h01001C,
  parameter int          TIMEOUT_CYCLES   = 4096
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        step,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [15:0] adc_data,
  output logic        ram_start,
  output logic        ram_wr,
  output logic [23:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic        ram_done,
  input  logic [15:0] ram_rdata,
  output logic        dac_start,
  output logic [15:0] dac_data,
  input  logic        dac_done,
  output logic        busy,
  output logic        overrun,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADC, S_RAM_WR, S_RAM_RD, S_DAC, S_ADV
  } state_t;

  state_t      state, state_next;
  logic        first;
  logic        expire;
  logic        timeout;
  logic        adc_ok, ram_ok, dac_ok;
  logic [23:0] w_ptr, r_ptr;

  // 25-bit sum so ptr + 2 can never wrap before the end-of-buffer compare.
  function automatic logic [23:0] next_ptr(input logic [23:0] p);
    logic [24:0] sum;
    sum = {1'b0, p} + 25'd2;
    return (sum > {1'b0, RAM_END_ADDR}) ? 24'd0 : sum[23:0];
  endfunction

  // A done arriving in the same cycle as its start pulse belongs to nothing we launched.
  assign adc_ok = adc_done & ~first;
  assign ram_ok = ram_done & ~first;
  assign dac_ok = dac_done & ~first;

`ifdef DELAY_SCHED_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;
  logic        fault_q;
  logic        wait_st;

  assign wait_st = (state == S_ADC) || (state == S_RAM_WR) ||
                   (state == S_RAM_RD) || (state == S_DAC);
  assign timeout = wait_st && (wd_cnt == TO_LAST);
  assign fault   = fault_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wd_cnt  <= 16'd0;
      fault_q <= 1'b0;
    end else begin
      if (state_next != state) wd_cnt <= 16'd0;
      else if (wait_st)        wd_cnt <= wd_cnt + 16'd1;
      if (expire) fault_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    expire     = 1'b0;
    case (state)
      S_IDLE:   if (step) state_next = S_ADC;
      S_ADC:    if (adc_ok) state_next = S_RAM_WR;
                else if (timeout) begin state_next = S_IDLE; expire = 1'b1; end
      S_RAM_WR: if (ram_ok) state_next = S_RAM_RD;
                else if (timeout) begin state_next = S_IDLE; expire = 1'b1; end
      S_RAM_RD: if (ram_ok) state_next = S_DAC;
                else if (timeout) begin state_next = S_IDLE; expire = 1'b1; end
      S_DAC:    if (dac_ok) state_next = S_ADV;
                else if (timeout) begin state_next = S_IDLE; expire = 1'b1; end
      S_ADV:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= S_IDLE;
      first     <= 1'b0;
      overrun   <= 1'b0;
      w_ptr     <= W_PTR_START_ADDR;
      r_ptr     <= R_PTR_START_ADDR;
      ram_wr    <= 1'b0;
      ram_addr  <= 24'd0;
      ram_wdata <= 16'd0;
      dac_data  <= 16'd0;
    end else begin
      state <= state_next;
      first <= (state_next != state);
      if (step && (state != S_IDLE)) overrun <= 1'b1;
      // Address and direction only move on entry so the engine sees them stable.
      if (state_next == S_RAM_WR && state != S_RAM_WR) begin
        ram_wr   <= 1'b1;
        ram_addr <= w_ptr;
      end
      if (state_next == S_RAM_RD && state != S_RAM_RD) begin
        ram_wr   <= 1'b0;
        ram_addr <= r_ptr;
      end
      if (state == S_ADC && adc_ok)    ram_wdata <= adc_data;
      if (state == S_RAM_RD && ram_ok) dac_data  <= ram_rdata;
      if (state == S_ADV) begin
        w_ptr <= next_ptr(w_ptr);
        r_ptr <= next_ptr(r_ptr);
      end
    end
  end

  assign adc_start = (state == S_ADC)    && first;
  assign ram_start = ((state == S_RAM_WR) || (state == S_RAM_RD)) && first;
  assign dac_start = (state == S_DAC)    && first;
  assign busy      = (state != S_IDLE);

endmodule
